// File: rtl/ycr1_memif_pkg.sv
// Shared memory-interface definitions: command and response encodings used on
// the instruction-memory router ports, plus the state type of the Wishbone bridge.
package ycr1_memif_pkg;

  typedef enum logic {
    YCR1_MEM_CMD_RD = 1'b0,
    YCR1_MEM_CMD_WR = 1'b1
  } type_ycr1_mem_cmd_e;

  typedef enum logic [1:0] {
    YCR1_MEM_RESP_NOTRDY = 2'b00,
    YCR1_MEM_RESP_RDY_OK = 2'b01,
    YCR1_MEM_RESP_RDY_ER = 2'b10
  } type_ycr1_mem_resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } type_ycr1_wbb_fsm_e;

endpackage

// File: rtl/ycr1_imem_wb_bridge_if.sv
// Bundle of the router-side fetch port and the Wishbone classic read port of the
// instruction-memory bridge. 'master' is the bridge view, 'slave' the environment
// view (router driving fetches plus the Wishbone slave answering them).
interface ycr1_imem_wb_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // router port
  logic          imem_req;
  logic          imem_cmd;
  logic [AW-1:0] imem_addr;
  logic          imem_req_ack;
  logic [DW-1:0] imem_rdata;
  logic [1:0]    imem_resp;
  // Wishbone port
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i;
  logic            wb_err_i;

  modport master (
    input  imem_req, imem_cmd, imem_addr, wb_dat_i, wb_ack_i, wb_err_i,
    output imem_req_ack, imem_rdata, imem_resp,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o
  );

  modport slave (
    output imem_req, imem_cmd, imem_addr, wb_dat_i, wb_ack_i, wb_err_i,
    input  imem_req_ack, imem_rdata, imem_resp,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o
  );
endinterface

// File: rtl/ycr1_imem_req_fifo.sv
// Small request FIFO holding accepted fetch entries. Pointers carry an extra
// wrap bit so full and empty are distinguished without a counter. The head
// entry is always visible combinationally.
module ycr1_imem_req_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  // Pointer advance; callers never push when full nor pop when empty.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; pointers alone define validity, and a reset-free array maps to plain RAM/flops.
    if (push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ycr1_imem_wb_bridge.sv
// Instruction-memory router port to Wishbone classic read master.
// Accepted fetches are queued in a small FIFO; one bus cycle is run at a time
// and results are returned in order as single-cycle imem_resp pulses.
// When the FIFO is empty an incoming request is used directly as the head so a
// zero-wait slave yields stb one cycle and a response two cycles after accept.
// Optional feature macro: YCR1_IMEM_WB_TIMEOUT_EN (bus-cycle watchdog of TIMEOUT clocks).
module ycr1_imem_wb_bridge
  import ycr1_memif_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input logic                  clk,
  input logic                  rst,
  ycr1_imem_wb_bridge_if.master bus
);
  localparam int EW = AW + 1;

  type_ycr1_wbb_fsm_e  state, state_next;
  type_ycr1_mem_resp_e resp, resp_next;
  logic                cyc, cyc_next;
  logic [AW-1:0]       adr, adr_next;
  logic [DW-1:0]       rdata, rdata_next;

  logic          fifo_full, fifo_empty;
  logic [EW-1:0] fifo_head;
  logic          fifo_push, fifo_pop;
  logic          req_push, req_err;
  logic          head_valid, head_err;
  logic [AW-1:0] head_addr;
  logic          consume;
  logic          timed_out;

  assign bus.imem_req_ack = !fifo_full;
  assign req_push = bus.imem_req && !fifo_full;
  assign req_err  = (bus.imem_cmd == YCR1_MEM_CMD_WR);

  // Head view: the queued head, or the incoming request when the queue is empty.
  assign head_valid = !fifo_empty || req_push;
  assign {head_addr, head_err} = fifo_empty ? {bus.imem_addr, req_err} : fifo_head;

  // A bypassed entry consumed in its arrival cycle never enters the FIFO.
  assign fifo_push = req_push && !(fifo_empty && consume);
  assign fifo_pop  = consume && !fifo_empty;

  ycr1_imem_req_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({bus.imem_addr, req_err}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

`ifdef YCR1_IMEM_WB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] timer;

  // Watchdog: zero outside BUS, counts BUS cycles; fires on the TIMEOUT-th one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               timer <= '0;
    else if (state != BUS) timer <= '0;
    else                   timer <= timer + 1'b1;
  end

  assign timed_out = (state == BUS) && (timer == TW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  // Next-state and next-output logic for the bridge FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_next = state;
    resp_next  = YCR1_MEM_RESP_NOTRDY;
    cyc_next   = cyc;
    adr_next   = adr;
    rdata_next = rdata;
    consume    = 1'b0;
    case (state)
      IDLE, RESP: begin
        state_next = IDLE;
        if (head_valid) begin
          if (head_err) begin
            consume    = 1'b1;
            resp_next  = YCR1_MEM_RESP_RDY_ER;
            state_next = RESP;
          end else begin
            cyc_next   = 1'b1;
            adr_next   = head_addr & {{(AW-2){1'b1}}, 2'b00};
            state_next = BUS;
          end
        end
      end
      BUS: begin
        if (bus.wb_ack_i || bus.wb_err_i || timed_out) begin
          cyc_next   = 1'b0;
          consume    = 1'b1;
          state_next = RESP;
          if (bus.wb_err_i || timed_out) begin
            resp_next = YCR1_MEM_RESP_RDY_ER;
          end else begin
            resp_next  = YCR1_MEM_RESP_RDY_OK;
            rdata_next = bus.wb_dat_i;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      resp  <= YCR1_MEM_RESP_NOTRDY;
      cyc   <= 1'b0;
      adr   <= '0;
      rdata <= '0;
    end else begin
      state <= state_next;
      resp  <= resp_next;
      cyc   <= cyc_next;
      adr   <= adr_next;
      rdata <= rdata_next;
    end
  end

  assign bus.imem_resp  = resp;
  assign bus.imem_rdata = rdata;
  assign bus.wb_cyc_o   = cyc;
  assign bus.wb_stb_o   = cyc;
  assign bus.wb_we_o    = 1'b0;
  assign bus.wb_adr_o   = adr;
  assign bus.wb_sel_o   = '1;

endmodule

// File: tb/tb_ycr1_imem_wb_bridge.sv
// Directed bench for ycr1_imem_wb_bridge. Inputs change 1ns after posedge,
// outputs are sampled on negedge. A background Wishbone slave answers after a
// programmable number of wait states with data {16'hC0DE, adr[15:0]} unless a
// fixed word is selected. The watchdog scenario runs only when
// YCR1_IMEM_WB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_ycr1_imem_wb_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ycr1_imem_wb_bridge_if #(.AW(32), .DW(32)) bus_if ();

  ycr1_imem_wb_bridge #(
    .AW         (32),
    .DW         (32),
    .FIFO_DEPTH (2),
    .TIMEOUT    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // slave configuration
  bit          slave_en    = 1'b1;
  int          slave_waits = 0;
  bit          slave_ack   = 1'b1;
  bit          slave_err   = 1'b0;
  bit          slave_fixed = 1'b0;
  logic [31:0] slave_word  = 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic req, input logic cmd, input logic [31:0] addr);
    bus_if.imem_req  = req;
    bus_if.imem_cmd  = cmd;
    bus_if.imem_addr = addr;
  endtask

  // Wait (bounded) for the next non-NOTRDY response; sampled on negedge.
  task automatic wait_resp(input string tag, output logic [1:0] r, output logic [31:0] d);
    bit seen = 1'b0;
    r = 2'b00;
    d = '0;
    for (int i = 0; i < 30 && !seen; i++) begin
      next_cycle();
      sample();
      if (bus_if.imem_resp != 2'b00) begin
        seen = 1'b1;
        r = bus_if.imem_resp;
        d = bus_if.imem_rdata;
      end
    end
    if (!seen) check({tag, "_no_resp"}, 64'd0, 64'd1);
  endtask

  // Wishbone slave model.
  int wcnt = 0;
  initial begin
    bus_if.wb_ack_i = 1'b0;
    bus_if.wb_err_i = 1'b0;
    bus_if.wb_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (slave_en) begin
        if (bus_if.wb_cyc_o && bus_if.wb_stb_o) begin
          if (wcnt == slave_waits) begin
            bus_if.wb_ack_i = slave_ack;
            bus_if.wb_err_i = slave_err;
            bus_if.wb_dat_i = slave_fixed ? slave_word : {16'hC0DE, bus_if.wb_adr_o[15:0]};
            wcnt = 0;
          end else begin
            bus_if.wb_ack_i = 1'b0;
            bus_if.wb_err_i = 1'b0;
            wcnt++;
          end
        end else begin
          bus_if.wb_ack_i = 1'b0;
          bus_if.wb_err_i = 1'b0;
          wcnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    drive_req(1'b0, 1'b0, 32'h0);

    // ---- reset state
    repeat (3) @(posedge clk);
    sample();
    check("rst_resp",   bus_if.imem_resp,    2'b00);
    check("rst_rdata",  bus_if.imem_rdata,   32'h0);
    check("rst_cyc",    bus_if.wb_cyc_o,     1'b0);
    check("rst_stb",    bus_if.wb_stb_o,     1'b0);
    check("rst_adr",    bus_if.wb_adr_o,     32'h0);
    check("rst_reqack", bus_if.imem_req_ack, 1'b1);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // ---- 1: single read, zero-wait slave, fixed data
    slave_fixed = 1'b1;
    slave_word  = 32'hDEADBEEF;
    drive_req(1'b1, 1'b0, 32'h0001_0040);             // cycle 0
    sample();
    check("t1_reqack_c0", bus_if.imem_req_ack, 1'b1);
    check("t1_resp_c0",   bus_if.imem_resp,    2'b00);
    next_cycle();
    drive_req(1'b0, 1'b0, 32'h0);                     // cycle 1
    sample();
    check("t1_cyc_c1",  bus_if.wb_cyc_o,  1'b1);
    check("t1_stb_c1",  bus_if.wb_stb_o,  1'b1);
    check("t1_adr_c1",  bus_if.wb_adr_o,  32'h0001_0040);
    check("t1_we_c1",   bus_if.wb_we_o,   1'b0);
    check("t1_sel_c1",  bus_if.wb_sel_o,  4'hF);
    check("t1_resp_c1", bus_if.imem_resp, 2'b00);
    next_cycle();                                     // cycle 2
    sample();
    check("t1_resp_c2",  bus_if.imem_resp,  2'b01);
    check("t1_rdata_c2", bus_if.imem_rdata, 32'hDEADBEEF);
    check("t1_cyc_c2",   bus_if.wb_cyc_o,   1'b0);
    next_cycle();                                     // cycle 3
    sample();
    check("t1_resp_c3",  bus_if.imem_resp,  2'b00);
    check("t1_rdata_c3", bus_if.imem_rdata, 32'hDEADBEEF);
    slave_fixed = 1'b0;

    // ---- 2: three back-to-back reads, 3 wait states
    slave_waits = 3;
    next_cycle();
    drive_req(1'b1, 1'b0, 32'h100);                   // cycle 0
    sample();
    check("t2_reqack_c0", bus_if.imem_req_ack, 1'b1);
    next_cycle();
    drive_req(1'b1, 1'b0, 32'h104);                   // cycle 1
    sample();
    check("t2_reqack_c1", bus_if.imem_req_ack, 1'b1);
    check("t2_adr_c1",    bus_if.wb_adr_o,     32'h100);
    next_cycle();
    drive_req(1'b1, 1'b0, 32'h108);                   // cycle 2
    sample();
    check("t2_reqack_c2", bus_if.imem_req_ack, 1'b0);
    next_cycle();                                     // cycle 3
    sample();
    check("t2_reqack_c3", bus_if.imem_req_ack, 1'b0);
    next_cycle();                                     // cycle 4: ack from slave
    sample();
    check("t2_reqack_c4", bus_if.imem_req_ack, 1'b0);
    check("t2_cyc_c4",    bus_if.wb_cyc_o,     1'b1);
    check("t2_resp_c4",   bus_if.imem_resp,    2'b00);
    next_cycle();                                     // cycle 5: first pop visible
    sample();
    check("t2_reqack_c5", bus_if.imem_req_ack, 1'b1);
    check("t2_resp0",     bus_if.imem_resp,    2'b01);
    check("t2_rdata0",    bus_if.imem_rdata,   32'hC0DE0100);
    next_cycle();
    drive_req(1'b0, 1'b0, 32'h0);
    sample();
    check("t2_adr1", bus_if.wb_adr_o, 32'h104);
    wait_resp("t2_r1", r, d);
    check("t2_resp1",  r, 2'b01);
    check("t2_rdata1", d, 32'hC0DE0104);
    wait_resp("t2_r2", r, d);
    check("t2_resp2",  r, 2'b01);
    check("t2_rdata2", d, 32'hC0DE0108);
    slave_waits = 0;
    repeat (2) next_cycle();

    // ---- 3: WRITE command -> error without bus cycle
    drive_req(1'b1, 1'b1, 32'h200);                   // cycle 0
    sample();
    check("t3_reqack_c0", bus_if.imem_req_ack, 1'b1);
    next_cycle();
    drive_req(1'b0, 1'b0, 32'h0);                     // cycle 1
    sample();
    check("t3_resp_c1",  bus_if.imem_resp,  2'b10);
    check("t3_cyc_c1",   bus_if.wb_cyc_o,   1'b0);
    check("t3_rdata_c1", bus_if.imem_rdata, 32'hC0DE0108);
    next_cycle();                                     // cycle 2
    sample();
    check("t3_resp_c2", bus_if.imem_resp, 2'b00);
    check("t3_cyc_c2",  bus_if.wb_cyc_o,  1'b0);

    // ---- 4: ack and err together -> error, rdata held
    slave_err = 1'b1;
    next_cycle();
    drive_req(1'b1, 1'b0, 32'h300);                   // cycle 0
    next_cycle();
    drive_req(1'b0, 1'b0, 32'h0);                     // cycle 1
    sample();
    check("t4_cyc_c1", bus_if.wb_cyc_o, 1'b1);
    next_cycle();                                     // cycle 2
    sample();
    check("t4_resp_c2",  bus_if.imem_resp,  2'b10);
    check("t4_rdata_c2", bus_if.imem_rdata, 32'hC0DE0108);
    check("t4_cyc_c2",   bus_if.wb_cyc_o,   1'b0);
    slave_err = 1'b0;
    next_cycle();

    // ---- 5: reset during an open bus cycle with two queued requests
    slave_en = 1'b0;
    bus_if.wb_ack_i = 1'b0;
    bus_if.wb_err_i = 1'b0;
    next_cycle();
    drive_req(1'b1, 1'b0, 32'h400);                   // cycle 0
    next_cycle();
    drive_req(1'b1, 1'b0, 32'h404);                   // cycle 1
    next_cycle();
    drive_req(1'b0, 1'b0, 32'h0);                     // cycle 2
    sample();
    check("t5_cyc_pre",    bus_if.wb_cyc_o,     1'b1);
    check("t5_reqack_pre", bus_if.imem_req_ack, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_cyc_async", bus_if.wb_cyc_o, 1'b0);
    check("t5_stb_async", bus_if.wb_stb_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.wb_ack_i = 1'b1;                           // late ack from slave
    bus_if.wb_dat_i = 32'h1234_5678;
    sample();
    check("t5_reqack_post", bus_if.imem_req_ack, 1'b1);
    next_cycle();
    bus_if.wb_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("t5_resp_%0d", i), bus_if.imem_resp,  2'b00);
      check($sformatf("t5_cyc_%0d", i),  bus_if.wb_cyc_o,   1'b0);
      check($sformatf("t5_rd_%0d", i),   bus_if.imem_rdata, 32'h0);
      next_cycle();
    end
    slave_en = 1'b1;

`ifdef YCR1_IMEM_WB_TIMEOUT_EN
    // ---- 6: watchdog expiry after 8 BUS cycles, then next request proceeds
    slave_ack = 1'b0;
    next_cycle();
    drive_req(1'b1, 1'b0, 32'h500);                   // cycle 0
    next_cycle();
    drive_req(1'b1, 1'b0, 32'h504);                   // cycle 1
    sample();
    check("t6_cyc_c1", bus_if.wb_cyc_o, 1'b1);
    next_cycle();
    drive_req(1'b0, 1'b0, 32'h0);                     // cycle 2
    repeat (6) next_cycle();                          // cycle 8
    sample();
    check("t6_cyc_c8",  bus_if.wb_cyc_o,  1'b1);
    check("t6_resp_c8", bus_if.imem_resp, 2'b00);
    next_cycle();                                     // cycle 9
    sample();
    check("t6_cyc_c9",  bus_if.wb_cyc_o,  1'b0);
    check("t6_resp_c9", bus_if.imem_resp, 2'b10);
    slave_ack = 1'b1;
    next_cycle();                                     // cycle 10
    sample();
    check("t6_cyc_c10", bus_if.wb_cyc_o, 1'b1);
    check("t6_adr_c10", bus_if.wb_adr_o, 32'h504);
    wait_resp("t6_r1", r, d);
    check("t6_resp1",  r, 2'b01);
    check("t6_rdata1", d, 32'hC0DE0504);
`endif

    repeat (2) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
